// File: rtl/arm_mem_arbiter.sv
// Arbiter for one unified single-ported memory shared between instruction
// fetch and load/store. Data requests win collisions; a starvation counter
// forces a fetch grant after STARVE_MAX consecutive data grants that left a
// fetch waiting. At most one access is outstanding at any time.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no access in flight; a request may be granted this cycle
// WAIT   | access in flight; lat_cnt counts down to the m_rdata cycle
module arm_mem_arbiter #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_we,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [0:0]        state_q, state_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              owner_q, owner_d;
    logic              is_store_q, is_store_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              gnt_i;
    logic              gnt_d;

    // Grant decision: IDLE only; gated by rst_b so all outputs drop at once in reset
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rst_b && (state_q == S_IDLE)) begin
            if (d_req && !(i_req && (starve_cnt_q == STARVE_LIM))) begin
                gnt_d = 1'b1;
            end else if (i_req) begin
                gnt_i = 1'b1;
            end
        end
    end

    // Memory request mux: driven only in the grant cycle, zero otherwise
    always_comb begin
        m_req   = gnt_i | gnt_d;
        m_addr  = '0;
        m_we    = '0;
        m_wdata = '0;
        if (gnt_d) begin
            m_addr  = d_addr;
            m_we    = d_we;
            m_wdata = d_wdata;
        end else if (gnt_i) begin
            m_addr  = i_addr;
        end
    end

    // Next-state: grant bookkeeping in IDLE, latency countdown and capture in WAIT
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        owner_d      = owner_q;
        is_store_d   = is_store_q;
        i_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_i || gnt_d) begin
                    state_d    = S_WAIT;
                    lat_cnt_d  = LAT_INIT;
                    owner_d    = gnt_d;
                    is_store_d = gnt_d && (d_we != 4'h0);
                    if (gnt_d && i_req) begin
                        if (starve_cnt_q != STARVE_LIM) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end else begin
                        starve_cnt_d = 4'd0;
                    end
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = is_store_q ? '0 : m_rdata;
                    end else begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = m_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= S_IDLE;
            lat_cnt_q    <= 4'd0;
            starve_cnt_q <= 4'd0;
            owner_q      <= 1'b0;
            is_store_q   <= 1'b0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            is_store_q   <= is_store_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign i_gnt    = gnt_i;
    assign d_gnt    = gnt_d;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state_q == S_WAIT);

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Bench for arm_mem_arbiter: hand-written corner sequences plus a vector
// table, with a scoreboard that predicts every rvalid pulse and its data.
module tb_arm_mem_arbiter;

    localparam int ADDR_W     = 30;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

    logic              clk;
    logic              rst_b;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_we;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_we;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              busy;

    arm_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] mem [logic [29:0]];
    logic [29:0] mem_addr;
    int          mem_cd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return {2'b00, a} ^ 32'hA5A5_0000;
    endfunction

    // Memory model and scoreboard, evaluated mid-cycle
    always @(negedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sb_q.delete();
            mem_cd  = 0;
            m_rdata = GARBAGE;
        end else begin
            bit   valid_now;
            bit   exp_iv;
            bit   exp_dv;
            exp_t e;
            valid_now = (mem_cd == 1);
            if (mem_cd > 0) mem_cd--;
            m_rdata = valid_now ? rd_word(mem_addr) : GARBAGE;

            exp_iv = 1'b0;
            exp_dv = 1'b0;
            if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
                chk("rvalid_timeout", 64'(cyc), 64'(sb_q[0].due));
                void'(sb_q.pop_front());
            end
            if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                if (e.is_d) begin
                    exp_dv = 1'b1;
                    if (d_rvalid) chk("d_rdata", 64'(d_rdata), 64'(e.data));
                end else begin
                    exp_iv = 1'b1;
                    if (i_rvalid) chk("i_rdata", 64'(i_rdata), 64'(e.data));
                end
            end
            chk("i_rvalid", 64'(i_rvalid), 64'(exp_iv));
            chk("d_rvalid", 64'(d_rvalid), 64'(exp_dv));

            if (i_gnt || d_gnt) begin
                e.is_d = d_gnt;
                e.due  = cyc + MEM_LAT + 1;
                if (d_gnt) e.data = (d_we != 4'h0) ? 32'h0 : rd_word(d_addr);
                else       e.data = rd_word(i_addr);
                sb_q.push_back(e);
                mem_addr = d_gnt ? d_addr : i_addr;
                mem_cd   = MEM_LAT;
                if (d_gnt && d_we != 4'h0) begin
                    logic [31:0] w;
                    w = rd_word(d_addr);
                    for (int b = 0; b < 4; b++)
                        if (d_we[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
                    mem[d_addr] = w;
                end
            end
        end
    end

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_we = 4'h0; d_wdata = '0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        chk("drain", 64'(sb_q.size()), 64'd0);
    endtask

    typedef struct {
        logic        ir;
        logic [29:0] ia;
        logic        dr;
        logic [29:0] da;
        logic [3:0]  dwe;
        logic [31:0] dwd;
        logic        eig;
        logic        edg;
        logic [29:0] ema;
        logic [3:0]  emwe;
        logic [31:0] emwd;
    } vec_t;
    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] ig_mask;
        logic [17:0] dg_mask;

        vecs[0] = '{1'b1, 30'h100, 1'b0, 30'h0,   4'h0, 32'h0,          1'b1, 1'b0, 30'h100, 4'h0, 32'h0};
        vecs[1] = '{1'b0, 30'h0,   1'b1, 30'h200, 4'h0, 32'h0,          1'b0, 1'b1, 30'h200, 4'h0, 32'h0};
        vecs[2] = '{1'b0, 30'h0,   1'b1, 30'h204, 4'h3, 32'h1234_5678,  1'b0, 1'b1, 30'h204, 4'h3, 32'h1234_5678};
        vecs[3] = '{1'b1, 30'h300, 1'b1, 30'h304, 4'h0, 32'h0,          1'b0, 1'b1, 30'h304, 4'h0, 32'h0};
        vecs[4] = '{1'b1, 30'h1,   1'b1, 30'h3FFF_FFFF, 4'hC, 32'hCAFE_F00D, 1'b0, 1'b1, 30'h3FFF_FFFF, 4'hC, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 30'h123, 1'b0, 30'h456, 4'hF, 32'hFFFF_FFFF,  1'b0, 1'b0, 30'h0,   4'h0, 32'h0};
        vecs[6] = '{1'b1, 30'h3FFF_FFFF, 1'b0, 30'h0, 4'h0, 32'h0,       1'b1, 1'b0, 30'h3FFF_FFFF, 4'h0, 32'h0};
        vecs[7] = '{1'b1, 30'h208, 1'b0, 30'h20C, 4'hF, 32'hFFFF_FFFF,  1'b1, 1'b0, 30'h208, 4'h0, 32'h0};
        vecs[8] = '{1'b0, 30'h0,   1'b1, 30'h204, 4'h0, 32'h0,          1'b0, 1'b1, 30'h204, 4'h0, 32'h0};

        mem[30'h40] = 32'hE3A0_0001;
        idle_inputs();
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
        cyc_sample();
        chk("reset_outputs", 64'({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, m_req, m_addr, m_we, busy}), 64'd0);
        chk("reset_rdata", 64'({d_rdata, m_wdata}), 64'd0);

        // Single fetch
        cyc_start(); i_req = 1'b1; i_addr = 30'h40;
        cyc_sample();
        chk("fetch_gnt", 64'({i_gnt, d_gnt, m_req}), 64'b101);
        chk("fetch_maddr", 64'(m_addr), 64'h40);
        cyc_start(); i_req = 1'b0;
        cyc_sample(); chk("fetch_busy1", 64'(busy), 64'd1);
        cyc_start(); cyc_sample(); chk("fetch_busy2", 64'(busy), 64'd1);
        cyc_start(); cyc_sample();
        chk("fetch_busy3", 64'(busy), 64'd0);
        chk("fetch_rvalid", 64'({i_rvalid, d_rvalid}), 64'b10);
        chk("fetch_rdata", 64'(i_rdata), 64'hE3A0_0001);
        cyc_start(); cyc_sample(); chk("fetch_rvalid_once", 64'(i_rvalid), 64'd0);

        // Collision: data first, fetch granted with the load's rvalid
        cyc_start(); i_req = 1'b1; i_addr = 30'h44; d_req = 1'b1; d_addr = 30'h80; d_we = 4'h0;
        cyc_sample();
        chk("coll_gnt", 64'({i_gnt, d_gnt}), 64'b01);
        chk("coll_maddr", 64'(m_addr), 64'h80);
        for (int k = 1; k <= 6; k++) begin
            cyc_start();
            if (k == 1) d_req = 1'b0;
            if (k == 4) i_req = 1'b0;
            cyc_sample();
            chk("coll_i_gnt", 64'(i_gnt), 64'(k == 3));
            if (k == 3) chk("coll_d_rvalid", 64'(d_rvalid), 64'd1);
            if (k == 6) chk("coll_i_rvalid", 64'(i_rvalid), 64'd1);
        end
        wait_drain();

        // Asynchronous reset while an access is in flight and d_req is held
        cyc_start(); d_req = 1'b1; d_addr = 30'h55;
        cyc_sample(); chk("rst_pre_gnt", 64'(d_gnt), 64'd1);
        cyc_start();
        #1 rst_b = 1'b0;
        #1;
        chk("rst_async_outputs", 64'({i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, m_req, m_addr, m_we, busy}), 64'd0);
        chk("rst_async_rdata", 64'({d_rdata, m_wdata}), 64'd0);
        d_req = 1'b0;
        #1 rst_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc_sample();
            chk("rst_idle_mreq", 64'({m_req, busy}), 64'd0);
        end

        // Starvation: both requesters held continuously
        cyc_start(); i_req = 1'b1; i_addr = 30'h60; d_req = 1'b1; d_addr = 30'h64; d_we = 4'h0;
        ig_mask = '0;
        dg_mask = '0;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) cyc_start();
            cyc_sample();
            ig_mask[k] = i_gnt;
            dg_mask[k] = d_gnt;
        end
        cyc_start(); idle_inputs();
        chk("starve_d_gnts", 64'(dg_mask), 64'((1 << 0) | (1 << 3) | (1 << 6) | (1 << 9) | (1 << 15)));
        chk("starve_i_gnts", 64'(ig_mask), 64'(1 << 12));
        wait_drain();

        // Full-word store
        cyc_start(); d_req = 1'b1; d_we = 4'hF; d_wdata = 32'hDEAD_BEEF; d_addr = 30'h10;
        cyc_sample();
        chk("store_gnt", 64'({i_gnt, d_gnt, m_req}), 64'b011);
        chk("store_mwe", 64'(m_we), 64'hF);
        chk("store_mwdata", 64'(m_wdata), 64'hDEAD_BEEF);
        chk("store_maddr", 64'(m_addr), 64'h10);
        for (int k = 1; k <= 3; k++) begin
            cyc_start();
            if (k == 1) idle_inputs();
            cyc_sample();
            chk("store_d_rvalid", 64'(d_rvalid), 64'(k == 3));
        end
        chk("store_rdata_zero", 64'(d_rdata), 64'd0);
        chk("store_no_i_rvalid", 64'(i_rvalid), 64'd0);
        wait_drain();

        // Reset pulse in the second cycle of a fetch
        cyc_start(); i_req = 1'b1; i_addr = 30'h70;
        cyc_sample(); chk("rstw_gnt", 64'(i_gnt), 64'd1);
        @(posedge clk);
        #1 i_req = 1'b0;
        #1 rst_b = 1'b0;
        #1 chk("rstw_async", 64'({busy, i_rvalid, m_req}), 64'd0);
        #1 rst_b = 1'b1;
        cyc_sample(); chk("rstw_idle", 64'(busy), 64'd0);
        cyc_start(); i_req = 1'b1; i_addr = 30'h74;
        cyc_sample(); chk("rstw_regrant", 64'(i_gnt), 64'd1);
        cyc_start(); i_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) cyc_start();
            cyc_sample();
            chk("rstw_i_rvalid", 64'(i_rvalid), 64'(k == 3));
        end
        wait_drain();

        // Vector table: one request cycle from IDLE, then drain
        for (int v = 0; v < 9; v++) begin
            cyc_start();
            i_req = vecs[v].ir; i_addr = vecs[v].ia;
            d_req = vecs[v].dr; d_addr = vecs[v].da; d_we = vecs[v].dwe; d_wdata = vecs[v].dwd;
            cyc_sample();
            chk("vec_gnt", 64'({i_gnt, d_gnt}), 64'({vecs[v].eig, vecs[v].edg}));
            chk("vec_mreq", 64'(m_req), 64'(vecs[v].eig | vecs[v].edg));
            chk("vec_mbus", 64'({m_addr, m_we}), 64'({vecs[v].ema, vecs[v].emwe}));
            chk("vec_mwdata", 64'(m_wdata), 64'(vecs[v].emwd));
            cyc_start(); idle_inputs();
            cyc_sample();
            chk("vec_busy", 64'(busy), 64'(vecs[v].eig | vecs[v].edg));
            wait_drain();
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arm_mem_arbiter.md
Name: arm_mem_arbiter

Overview:
Arbitrates one unified single-ported memory between the instruction-fetch requester and the load/store requester of the ARM core. It lets the datapath run on a shared instruction/data memory. The arbiter handles grant, fixed-latency wait and response routing. Data accesses have priority, and a starvation counter guarantees fetch progress. Only one access is outstanding at a time.

Parameters:
ADDR_W, 30, word-address width (byte address bits [31:2])
DATA_W, 32, data width
MEM_LAT, 2, cycles from memory request to valid m_rdata; legal range 1..15
STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  reset, asynchronous, active-low
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  ADDR_W  fetch word address
i_gnt  out  1  fetch accepted this cycle
i_rvalid  out  1  one-cycle pulse; i_rdata valid
i_rdata  out  DATA_W  fetched word
d_req  in  1  load/store request; held with d_addr, d_we, d_wdata until d_gnt
d_addr  in  ADDR_W  data word address
d_we  in  4  byte write enables; 0 means load
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse; load data or store completion
d_rdata  out  DATA_W  load data; 0 for stores
m_req  out  1  memory request strobe
m_addr  out  ADDR_W  memory address
m_we  out  4  memory byte write enables
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after m_req
busy  out  1  access in flight (state WAIT)

Behaviour:
- States:
  - IDLE.
  - WAIT: down-counter lat_cnt, 4 bits.
  - Registers: owner (0 = fetch, 1 = data), is_store, starve_cnt (4 bits), rvalid/rdata output registers.
- Reset (rst_b low, async): state IDLE, lat_cnt 0, starve_cnt 0, owner 0, is_store 0. All outputs 0, including i_rdata and d_rdata.
- Reset mid-WAIT aborts the access. No rvalid is produced after reset release.
- Grant happens in IDLE only, combinationally in the same cycle as the request:
  - d_req and not i_req → grant data.
  - i_req and not d_req → grant fetch.
  - Both asserted → grant data, unless starve_cnt == STARVE_MAX, then grant fetch.
- On a grant in cycle T:
  - gnt = 1 for exactly cycle T.
  - m_req = 1; m_addr, m_we and m_wdata come from the winner. m_we and m_wdata are 0 for a fetch.
  - Next state WAIT, lat_cnt = MEM_LAT-1; owner and is_store are latched.
- Outside grant cycles, m_req, m_addr, m_we, m_wdata and all gnt outputs are 0.
- WAIT: lat_cnt decrements each cycle. In the cycle where lat_cnt == 0 (cycle T+MEM_LAT):
  - m_rdata is captured into the owner's rdata register (d_rdata = 0 if is_store).
  - The owner's rvalid is set for the next cycle.
  - State returns to IDLE.
- Total latency: rvalid is high in cycle T+MEM_LAT+1.
- rvalid and rdata are registered. Only the owner's rvalid pulses, for one cycle.
- An rdata output holds its value until that owner's next capture.
- IDLE in cycle T+MEM_LAT+1 may grant a new request in that same cycle, while the previous rvalid is high. Back-to-back throughput is one access per MEM_LAT+1 cycles.
- starve_cnt update on each grant:
  - Data granted while i_req = 1 → increment (saturates at STARVE_MAX).
  - Data granted while i_req = 0 → reset to 0.
  - Fetch granted → reset to 0.
- Requests arriving in WAIT are not granted. The requester must keep them asserted and stable.
- A requester dropping req before gnt is legal. The request is simply lost.
- busy = 1 exactly while state is WAIT.

Test Plan:
1. Reset: assert rst_b = 0 mid-sim with d_req = 1 → all outputs 0 asynchronously. After release with no requests, m_req stays 0.
2. Single fetch (MEM_LAT = 2): i_req with i_addr = 0x40 in cycle 1; memory drives m_rdata = 0xE3A00001 in cycle 3.
   - Required: i_gnt, m_req and m_addr = 0x40 in cycle 1; busy in cycles 2–3.
   - Required: i_rvalid = 1 with i_rdata = 0xE3A00001 in cycle 4 only; d_rvalid stays 0.
3. Collision: i_req and d_req (load, d_addr = 0x80) asserted in cycle 1.
   - Required: d_gnt in cycle 1, d_rvalid in cycle 4.
   - Required: i_gnt in cycle 4 (same cycle as d_rvalid), i_rvalid in cycle 7.
4. Starvation (STARVE_MAX = 4): d_req and i_req held continuously.
   - Required: d_gnt in cycles 1, 4, 7, 10; i_gnt in cycle 13; d_gnt again in cycle 16.
5. Store: d_req with d_we = 4'hF, d_wdata = 0xDEADBEEF, d_addr = 0x10.
   - Required: m_we = 4'hF, m_wdata = 0xDEADBEEF and m_addr = 0x10 in the grant cycle.
   - Required: d_rvalid pulses 3 cycles later with d_rdata = 0; i_rvalid stays 0.
6. Reset during WAIT: pulse rst_b low in cycle 2 of a fetch → i_rvalid never asserts, state is IDLE, and a new i_req is granted right after release.
